// File: rtl/led_frame_sequencer_if.sv
// led_frame_sequencer_if
//   Control/data bundle between the user/config logic and the LED frame
//   sequencer.
//   master : drives play, step, last_frame, wr_en, wr_addr and wr_data.
//            Observes ens, frame_idx, frame_tick and running.
//   slave  : the sequencer itself, with the opposite directions.
interface led_frame_sequencer_if #(
   parameter int ADDR_W = 3
);
   logic              play;
   logic              step;
   logic [ADDR_W-1:0] last_frame;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [34:0]       wr_data;
   logic [34:0]       ens;
   logic [ADDR_W-1:0] frame_idx;
   logic              frame_tick;
   logic              running;

   modport master (
      output play, step, last_frame, wr_en, wr_addr, wr_data,
      input  ens, frame_idx, frame_tick, running
   );

   modport slave (
      input  play, step, last_frame, wr_en, wr_addr, wr_data,
      output ens, frame_idx, frame_tick, running
   );
endinterface

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer
//   Animation controller for the 5x7 LED matrix. It holds a bank of 35-bit
//   frames and presents one of them on ens, which feeds scan_en.
//   Frames advance in one of two ways:
//     - on a dwell timer while in RUN;
//     - on a step rising edge while in STOP.
//   Ports:
//     CLOCK_50 : system clock.
//     rst      : asynchronous reset, active high.
//     bus      : slave side of led_frame_sequencer_if. It carries play, step,
//                last_frame and the frame write port in, and ens, frame_idx,
//                frame_tick and running out.
module led_frame_sequencer #(
   parameter int NUM_FRAMES = 8,
   parameter int ADDR_W     = 3,
   parameter int DWELL      = 12_500_000,
   parameter int CNT_W      = 24
) (
   input  logic                  CLOCK_50,
   input  logic                  rst,
   led_frame_sequencer_if.slave  bus
);

   typedef enum logic {ST_STOP, ST_RUN} state_t;

   localparam int                SEL_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam logic [ADDR_W-1:0] LAST_MAX = ADDR_W'(NUM_FRAMES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DWELL - 1);

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_step_d;
   logic [ADDR_W-1:0] r_idx, w_idx_nxt, w_lastc;
   logic [34:0]       r_ens, w_ens_nxt;
   logic              r_tick;
   logic              w_adv;
   logic              w_wr_ok;
   logic [SEL_W-1:0]  w_rd_sel;
   logic [34:0]       r_slot [NUM_FRAMES];

   // Loop end is clamped so an oversized last_frame never selects an empty slot.
   assign w_lastc  = (bus.last_frame > LAST_MAX) ? LAST_MAX : bus.last_frame;
   assign w_wr_ok  = bus.wr_en && ({1'b0, bus.wr_addr} < (ADDR_W+1)'(NUM_FRAMES));
   assign w_rd_sel = w_idx_nxt[SEL_W-1:0];

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) r_state <= ST_STOP;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_adv       = 1'b0;
      case (r_state)
         ST_STOP: begin
            // play wins over a coincident step edge: go RUN with no advance.
            if (bus.play)                     w_state_nxt = ST_RUN;
            else if (bus.step && !r_step_d)   w_adv       = 1'b1;
         end
         ST_RUN: begin
            if (!bus.play) w_state_nxt = ST_STOP;
            if (r_cnt == CNT_MAX) w_adv     = 1'b1;
            else                  w_cnt_nxt = r_cnt + 1'b1;
         end
         default: w_state_nxt = ST_STOP;
      endcase
   end

   // The next index is computed combinationally so that ens and frame_idx
   // update together on the same edge.
   always_comb begin
      w_idx_nxt = r_idx;
      if (w_adv) w_idx_nxt = (r_idx >= w_lastc) ? '0 : r_idx + 1'b1;
      // A write to the slot being selected this edge bypasses the bank.
      if (w_wr_ok && (bus.wr_addr == w_idx_nxt)) w_ens_nxt = bus.wr_data;
      else                                       w_ens_nxt = r_slot[w_rd_sel];
   end

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_step_d <= 1'b0;
         r_idx    <= '0;
         r_ens    <= '0;
         r_tick   <= 1'b0;
         for (int i = 0; i < NUM_FRAMES; i++) r_slot[i] <= '0;
      end else begin
         r_cnt    <= w_cnt_nxt;
         r_step_d <= bus.step;
         r_idx    <= w_idx_nxt;
         r_ens    <= w_ens_nxt;
         r_tick   <= w_adv;
         for (int i = 0; i < NUM_FRAMES; i++)
            if (w_wr_ok && (bus.wr_addr == ADDR_W'(i))) r_slot[i] <= bus.wr_data;
      end
   end

   assign bus.ens        = r_ens;
   assign bus.frame_idx  = r_idx;
   assign bus.frame_tick = r_tick;
   assign bus.running    = (r_state == ST_RUN);

endmodule

// File: tb/tb_led_frame_sequencer.sv
module tb_led_frame_sequencer;
   localparam int NF = 8;
   localparam int AW = 4;   // wide enough to present out-of-range write addresses
   localparam int DW = 4;

   logic CLOCK_50 = 1'b0;
   logic rst      = 1'b1;
   int   n_vec    = 0;
   int   n_err    = 0;
   int   n_tick;

   led_frame_sequencer_if #(.ADDR_W(AW)) bus ();

   led_frame_sequencer #(.NUM_FRAMES(NF), .ADDR_W(AW), .DWELL(DW), .CNT_W(3)) dut (
      .CLOCK_50 (CLOCK_50),
      .rst      (rst),
      .bus      (bus)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic step_pulse();
      bus.step = 1'b1; tick(); n_tick += int'(bus.frame_tick);
      bus.step = 1'b0; tick(); n_tick += int'(bus.frame_tick);
   endtask

   initial begin
      logic [34:0] seq [3];
      seq[0] = 35'h1; seq[1] = 35'h3F; seq[2] = 35'h5;
      bus.play = 0; bus.step = 0; bus.last_frame = '0;
      bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
      tick(); tick();
      chk("rst_ens", bus.ens, 0);
      chk("rst_idx", bus.frame_idx, 0);
      chk("rst_run", bus.running, 0);
      chk("rst_tick", bus.frame_tick, 0);
      rst = 0;

      // 1: reset asserted mid-play acts immediately and clears the bank
      bus.wr_en = 1; bus.wr_addr = 0; bus.wr_data = 35'h1F; tick();
      chk("t1_wr_bypass", bus.ens, 35'h1F);
      bus.wr_en = 0; bus.play = 1; tick(); tick();
      chk("t1_running", bus.running, 1);
      #2 rst = 1;
      #1;
      chk("t1_async_ens", bus.ens, 0);
      chk("t1_async_idx", bus.frame_idx, 0);
      chk("t1_async_run", bus.running, 0);
      bus.play = 0; tick(); rst = 0; tick();
      chk("t1_slot0_clr", bus.ens, 0);

      // 2: three-frame loop, each frame held DWELL cycles
      bus.last_frame = 2;
      for (int i = 0; i < 3; i++) begin
         bus.wr_en = 1; bus.wr_addr = AW'(i); bus.wr_data = seq[i]; tick();
      end
      bus.wr_en = 0;
      chk("t2_ens_pre", bus.ens, 35'h1);
      bus.play = 1; tick();
      chk("t2_running", bus.running, 1);
      chk("t2_ens_e0", bus.ens, 35'h1);
      n_tick = 0;
      for (int j = 1; j <= 16; j++) begin
         tick();
         n_tick += int'(bus.frame_tick);
         chk($sformatf("t2_idx_%0d", j), bus.frame_idx, 64'((j / DW) % 3));
         chk($sformatf("t2_ens_%0d", j), bus.ens, seq[(j / DW) % 3]);
         chk($sformatf("t2_tick_%0d", j), bus.frame_tick, 64'(j % DW == 0));
      end
      chk("t2_tick_cnt", n_tick, 4);

      // 3: stop on frame 1, then manual stepping
      bus.play = 0; tick();
      chk("t3_running", bus.running, 0);
      chk("t3_ens_hold", bus.ens, 35'h3F);
      n_tick = 0;
      bus.step = 1; tick(); n_tick += int'(bus.frame_tick);
      chk("t3_idx_a", bus.frame_idx, 2);
      chk("t3_ens_a", bus.ens, 35'h5);
      bus.step = 0; tick(); n_tick += int'(bus.frame_tick);
      bus.step = 1;
      for (int k = 0; k < 5; k++) begin
         tick(); n_tick += int'(bus.frame_tick);
      end
      chk("t3_idx_held", bus.frame_idx, 0);
      bus.step = 0; tick(); n_tick += int'(bus.frame_tick);
      step_pulse();
      chk("t3_idx_c", bus.frame_idx, 1);
      chk("t3_ens_c", bus.ens, 35'h3F);
      chk("t3_tick_cnt", n_tick, 3);
      chk("t3_still_stop", bus.running, 0);

      // 4: lowering last_frame below the current index wraps at next advance
      bus.last_frame = 7;
      for (int k = 0; k < 4; k++) step_pulse();
      chk("t4_idx5", bus.frame_idx, 5);
      chk("t4_ens5", bus.ens, 0);
      bus.play = 1; tick();
      bus.last_frame = 3;
      for (int k = 0; k < 3; k++) tick();
      chk("t4_idx_hold", bus.frame_idx, 5);
      tick();
      chk("t4_wrap_idx", bus.frame_idx, 0);
      chk("t4_wrap_ens", bus.ens, 35'h1);
      chk("t4_wrap_tick", bus.frame_tick, 1);

      // 5: write to the newly selected slot on the advance edge; bad addresses
      for (int k = 0; k < 3; k++) tick();
      bus.wr_en = 1; bus.wr_addr = 1; bus.wr_data = 35'h7FFFFFFFF; tick();
      chk("t5_adv_idx", bus.frame_idx, 1);
      chk("t5_adv_ens", bus.ens, 35'h7FFFFFFFF);
      bus.wr_data = 35'h2AA; tick();
      chk("t5_live_wr", bus.ens, 35'h2AA);
      bus.wr_addr = 9; bus.wr_data = '0; tick();
      chk("t5_oob9", bus.ens, 35'h2AA);
      bus.wr_addr = 8; tick();
      chk("t5_oob8", bus.ens, 35'h2AA);
      bus.wr_en = 0; tick();
      chk("t5_next_idx", bus.frame_idx, 2);
      chk("t5_next_ens", bus.ens, 35'h5);
      bus.play = 0; tick();
      chk("t5_stop", bus.running, 0);

      // 6: play and step edge together while stopped: RUN, no step advance
      bus.last_frame = 2;
      bus.play = 1; bus.step = 1; tick();
      chk("t6_running", bus.running, 1);
      chk("t6_idx", bus.frame_idx, 2);
      chk("t6_tick", bus.frame_tick, 0);
      n_tick = 0;
      for (int k = 0; k < 3; k++) begin
         tick(); n_tick += int'(bus.frame_tick);
      end
      chk("t6_no_tick", n_tick, 0);
      chk("t6_idx_hold", bus.frame_idx, 2);
      tick();
      chk("t6_adv_idx", bus.frame_idx, 0);
      chk("t6_adv_tick", bus.frame_tick, 1);
      chk("t6_slot0_kept", bus.ens, 35'h1);
      bus.step = 0; bus.play = 0; tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
